// File: rtl/result_fifo_pkg.sv
// Shared defaults and width helpers for the result FIFO slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package result_fifo_pkg;

    // Default word width, matching the upstream 16-bit buffer stage.
    localparam int RESULT_FIFO_K_DEFAULT     = 16;
    // Default storage depth; must be a power of two, at least 2.
    localparam int RESULT_FIFO_DEPTH_DEFAULT = 4;

    // Pointer width for a given depth: pointers wrap modulo depth for free.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy width for a given depth: one extra bit so count can reach depth.
    function automatic int cntWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int RESULT_FIFO_PTR_W_DEFAULT = ptrWidth(RESULT_FIFO_DEPTH_DEFAULT);
    localparam int RESULT_FIFO_CNT_W_DEFAULT = cntWidth(RESULT_FIFO_DEPTH_DEFAULT);

endpackage

// File: rtl/result_fifo_mem.sv
// Storage array for result_fifo: DEPTH x K, one write port, one async read port.
// Latency: write lands on the clock edge; read is combinational from the address.
// Backpressure: none; the owner decides when writes are legal.
module fifo_mem #(
    parameter int K     = 16,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          wrEn,
    input  logic [PW-1:0] wrAddr,
    input  logic [K-1:0]  wrData,
    input  logic [PW-1:0] rdAddr,
    output logic [K-1:0]  rdData
);

    // Deliberately not reset: the owner masks the read data while empty.
    logic [K-1:0] mem [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO between the 16-bit buffer stage and the consumer.
// Latency: a word pushed into an empty FIFO is visible on out_data the next cycle.
// Backpressure: in_ready drops only when full; it does not depend on out_ready.
module result_fifo
    import result_fifo_pkg::*;
#(
    parameter int K     = RESULT_FIFO_K_DEFAULT,
    parameter int DEPTH = RESULT_FIFO_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [K-1:0]               in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [K-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [cntWidth(DEPTH)-1:0] count
);

    localparam int PW = ptrWidth(DEPTH);
    localparam int CW = cntWidth(DEPTH);

    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] occ;
    logic [K-1:0]  headData;
    logic          doPush;
    logic          doPop;
    logic          memWrEn;

    // Handshake flags derive only from registered occupancy, so they are glitch-free.
    always_comb begin
        in_ready  = (occ != CW'(DEPTH));
        out_valid = (occ != '0);
        doPush    = in_valid && in_ready;
        doPop     = out_valid && out_ready;
        // A reset or flush edge must not leave a half-completed write behind.
        memWrEn   = doPush && !rst && !clear;
        out_data  = out_valid ? headData : '0;
    end

    assign count = occ;

    // Pointer and occupancy update; rst outranks clear, which outranks push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    fifo_mem #(
        .K     (K),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk    (clk),
        .wrEn   (memWrEn),
        .wrAddr (wrPtr),
        .wrData (in_data),
        .rdAddr (rdPtr),
        .rdData (headData)
    );

endmodule

// File: tb/tb_result_fifo.sv
// Scoreboard bench for result_fifo: words queued on accept, compared on pop.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: the model tracks occupancy and predicts in_ready/out_valid.
module tb_result_fifo;

    localparam int K     = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [K-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [K-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count;

    int total = 0;
    int bad   = 0;

    logic [K-1:0] sb[$];
    int           mCount = 0;

    always #5 clk = ~clk;

    result_fifo #(.K(K), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, check state, update model, advance.
    task automatic cyc(input logic v, input logic [K-1:0] d, input logic r, input logic c);
        logic [K-1:0] expWord;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        #1;
        checkVal("count", 32'(count), 32'(mCount));
        checkVal("in_ready", 32'(in_ready), 32'(mCount != DEPTH));
        checkVal("out_valid", 32'(out_valid), 32'(mCount != 0));
        if (mCount == 0) begin
            checkVal("out_data_empty", 32'(out_data), 32'h0);
        end
        if (c) begin
            sb.delete();
        end else begin
            if (r && mCount != 0) begin
                expWord = sb.pop_front();
                checkVal("out_data", 32'(out_data), 32'(expWord));
            end
            if (v && mCount != DEPTH) begin
                sb.push_back(d);
            end
        end
        mCount = sb.size();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset edge with traffic applied; everything queued is discarded.
    task automatic doReset(input logic v, input logic r);
        rst       = 1'b1;
        in_valid  = v;
        in_data   = 16'hBEEF;
        out_ready = r;
        clear     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        mCount = 0;
    endtask

    initial begin
        logic [K-1:0] burst [4];
        burst[0] = 16'hA5A5;
        burst[1] = 16'h0001;
        burst[2] = 16'hFFFF;
        burst[3] = 16'h1234;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        doReset(1'b0, 1'b0);

        // Reset then idle.
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Fill to full with the consumer stalled, then try a fifth push.
        for (int i = 0; i < 4; i++) cyc(1'b1, burst[i], 1'b0, 1'b0);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
        // Drain in order.
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Steady stream: one word in, one word out, every cycle.
        for (int i = 0; i < 20; i++) cyc(1'b1, K'(i), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Wrap: ten rounds of fill-three, drain-three.
        for (int rnd = 0; rnd < 10; rnd++) begin
            for (int i = 0; i < 3; i++) cyc(1'b1, K'(16'h3000 + rnd * 3 + i), 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Full with push and pop offered: only the pop happens, then the retry lands.
        for (int i = 0; i < 4; i++) cyc(1'b1, K'(16'h4400 + i), 1'b0, 1'b0);
        cyc(1'b1, 16'h4455, 1'b1, 1'b0);
        cyc(1'b1, 16'h4455, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Flush at three entries with traffic on both sides.
        for (int i = 0; i < 3; i++) cyc(1'b1, K'(16'h5500 + i), 1'b0, 1'b0);
        cyc(1'b1, 16'h55AA, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        // Stale entries must not reappear after the flush.
        cyc(1'b1, 16'h5A5A, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-stream at two entries.
        for (int i = 0; i < 2; i++) cyc(1'b1, K'(16'h6600 + i), 1'b0, 1'b0);
        doReset(1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 16'h7777, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        checkVal("sb_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_fifo.md
RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 Parameter K, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 4, number of storage entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clear  input  1  synchronous flush; empties FIFO, contents discarded.
REQ-006 in_data  input  K  word from the upstream 16-bit buffer stage.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  FIFO can accept a word this cycle.
REQ-009 out_data  output  K  head-of-queue word.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream consumes head this cycle.
REQ-012 count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Function
REQ-013 Push occurs on a rising edge when in_valid && in_ready; in_data is written at the write pointer, and the write pointer advances.
REQ-014 Pop occurs on a rising edge when out_valid && out_ready; the read pointer advances.
REQ-015 in_ready = (count != DEPTH), combinational from registered state only; no dependence on out_ready.
REQ-016 out_valid = (count != 0); out_data = entry at read pointer when out_valid, else all zeros (first-word fall-through).
REQ-017 Latency: word pushed at edge N appears on out_data/out_valid in the cycle after edge N when FIFO was empty.
REQ-018 Order strictly preserved; every accepted word delivered exactly once, unmodified, full K bits.
REQ-019 Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH, with no skipped or repeated slots.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-021 Full (count = DEPTH): in_ready low, push ignored regardless of in_valid; a pop that cycle leaves count = DEPTH-1.
REQ-022 Empty (count = 0): out_valid low, out_ready ignored; a push that cycle leaves count = 1.
REQ-023 in_valid while in_ready low: no state change; upstream holds data (no sticky error, no drop).
REQ-024 clear high: next state count = 0, both pointers 0; push and pop in the same cycle are discarded.
REQ-025 Priority: rst > clear > push/pop.

Reset
REQ-026 rst high at a rising edge: count = 0, pointers = 0, out_valid = 0, in_ready = 1, out_data = 0 from the following cycle.
REQ-027 Storage array SHALL NOT be reset; no stale word may reach out_data after reset because of REQ-016.
REQ-028 rst asserted mid-stream discards all queued words; no partial push or pop completes on that edge.
REQ-029 No asynchronous path from rst to any flop.

Structure
REQ-030 K, DEPTH defaults and the derived pointer/count widths are defined in the shared package result_fifo_pkg.
REQ-031 Storage is a single sub-module fifo_mem (DEPTH x K, one write port, one asynchronous read port, no reset).
REQ-032 Pointer, count and handshake logic reside in result_fifo; no latches; all outputs glitch-free functions of registered state.

Verification
REQ-033 Reset then idle: rst 1 cycle -> count 0, out_valid 0, in_ready 1, out_data 16'h0000.
REQ-034 Push 16'hA5A5, 16'h0001, 16'hFFFF, 16'h1234 with out_ready 0 -> count 4, in_ready 0; fifth push 16'hDEAD ignored; then out_ready 1 pops A5A5, 0001, FFFF, 1234 in order, count 0.
REQ-035 Steady stream, in_valid and out_ready held 1 for 20 cycles with incrementing data 0..19 -> every value out in order, count stays 1 after first push, no bubbles.
REQ-036 Wrap: 10 fill/drain rounds of 3 words each -> pointers wrap, all 30 words correct and ordered.
REQ-037 Full with simultaneous in_valid and out_ready -> only pop occurs, count 4 -> 3, pushed word not accepted until next cycle.
REQ-038 clear asserted at count 3 with in_valid and out_ready high -> next cycle count 0, out_valid 0, in_ready 1; rst asserted at count 2 -> same result.
